// File: rtl/jstk_spi_poller_if.sv
// Pin and data bundle between the PmodJSTK poller and its surroundings.
// master: the poller side; slave: joystick pins plus game-logic consumer.
interface jstk_spi_poller_if;
  logic       poll_en;
  logic [1:0] led_cmd;
  logic       MISO;
  logic       SS;
  logic       SCLK;
  logic       MOSI;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic [2:0] buttons;
  logic       data_valid;
  logic       busy;

  modport master (
    input  poll_en, led_cmd, MISO,
    output SS, SCLK, MOSI, x_pos, y_pos, buttons, data_valid, busy
  );

  modport slave (
    output poll_en, led_cmd, MISO,
    input  SS, SCLK, MOSI, x_pos, y_pos, buttons, data_valid, busy
  );
endinterface

// File: rtl/jstk_spi_poller.sv
// SPI mode-0 master that polls the PmodJSTK with one 5-byte frame per POLL_PERIOD
// and publishes X/Y/buttons atomically with a one-cycle data_valid pulse.
module jstk_spi_poller #(
  parameter int unsigned CLK_DIV     = 50,
  parameter int unsigned SS_SETUP    = 1500,
  parameter int unsigned BYTE_GAP    = 1000,
  parameter int unsigned POLL_PERIOD = 1000000
) (
  input logic                ClkPort,
  input logic                Reset,
  jstk_spi_poller_if.master  bus
);

  localparam int unsigned TMax0 = (CLK_DIV > SS_SETUP) ? CLK_DIV : SS_SETUP;
  localparam int unsigned TMax  = (TMax0 > BYTE_GAP) ? TMax0 : BYTE_GAP;
  localparam int unsigned TW    = $clog2(TMax);
  localparam int unsigned PW    = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;

  typedef enum logic [2:0] {StIdle, StSetup, StXfer, StGap, StDone, StWait} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          phase_q, phase_d;   // 0: SCLK low half, 1: SCLK high half
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    byte_q, byte_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [6:0]    tx_q, tx_d;         // remaining bits of the byte after the one on MOSI
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    rx0_q, rx0_d;
  logic [1:0]    rx1_q, rx1_d;
  logic [7:0]    rx2_q, rx2_d;
  logic [1:0]    rx3_q, rx3_d;
  logic          ss_q, ss_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic [9:0]    x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic [2:0]    btn_q, btn_d;
  logic          dv_q, dv_d;
  logic          busy_q, busy_d;
  logic          start;
  logic          poll_done;

  assign poll_done = (poll_q == PW'(POLL_PERIOD - 1));

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    poll_d  = poll_done ? poll_q : poll_q + PW'(1);
    tx_d    = tx_q;
    rx_d    = rx_q;
    rx0_d   = rx0_q;
    rx1_d   = rx1_q;
    rx2_d   = rx2_q;
    rx3_d   = rx3_q;
    ss_d    = ss_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    x_d     = x_q;
    y_d     = y_q;
    btn_d   = btn_q;
    dv_d    = 1'b0;
    busy_d  = busy_q;
    start   = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.poll_en) start = 1'b1;
      end
      StSetup: begin
        // The setup window doubles as the low half of the very first bit.
        if (timer_q == TW'(SS_SETUP - 1)) begin
          state_d = StXfer;
          timer_d = '0;
          phase_d = 1'b1;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[6:0], bus.MISO};
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StXfer: begin
        if (timer_q == TW'(CLK_DIV - 1)) begin
          timer_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            sclk_d  = 1'b1;
            rx_d    = {rx_q[6:0], bus.MISO};
          end else begin
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            if (bit_q == 3'd7) begin
              bit_d  = '0;
              tx_d   = '0;
              mosi_d = 1'b0;
              state_d = StGap;
              case (byte_q)
                3'd0:    rx0_d = rx_q;
                3'd1:    rx1_d = rx_q[1:0];
                3'd2:    rx2_d = rx_q;
                3'd3:    rx3_d = rx_q[1:0];
                default: begin
                  state_d = StDone;
                  ss_d    = 1'b1;
                  busy_d  = 1'b0;
                  dv_d    = 1'b1;
                  x_d     = {rx1_q, rx0_q};
                  y_d     = {rx3_q, rx2_q};
                  btn_d   = rx_q[2:0];
                end
              endcase
            end else begin
              bit_d  = bit_q + 3'd1;
              mosi_d = tx_q[6];
              tx_d   = {tx_q[5:0], 1'b0};
            end
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StGap: begin
        if (timer_q == TW'(BYTE_GAP - 1)) begin
          state_d = StXfer;
          timer_d = '0;
          phase_d = 1'b0;
          byte_d  = byte_q + 3'd1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StDone, StWait: begin
        state_d = StWait;
        if (poll_done) begin
          if (bus.poll_en) start = 1'b1;
          else             state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      state_d = StSetup;
      ss_d    = 1'b0;
      busy_d  = 1'b1;
      mosi_d  = 1'b1;                  // bit 7 of the LED command byte
      tx_d    = {5'b00000, bus.led_cmd};
      poll_d  = '0;
      timer_d = '0;
      phase_d = 1'b0;
      bit_d   = '0;
      byte_d  = '0;
      rx_d    = '0;
    end
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      timer_q <= '0;
      phase_q <= 1'b0;
      bit_q   <= '0;
      byte_q  <= '0;
      poll_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rx0_q   <= '0;
      rx1_q   <= '0;
      rx2_q   <= '0;
      rx3_q   <= '0;
      ss_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      btn_q   <= '0;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      poll_q  <= poll_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rx0_q   <= rx0_d;
      rx1_q   <= rx1_d;
      rx2_q   <= rx2_d;
      rx3_q   <= rx3_d;
      ss_q    <= ss_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      x_q     <= x_d;
      y_q     <= y_d;
      btn_q   <= btn_d;
      dv_q    <= dv_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.SS         = ss_q;
  assign bus.SCLK       = sclk_q;
  assign bus.MOSI       = mosi_q;
  assign bus.x_pos      = x_q;
  assign bus.y_pos      = y_q;
  assign bus.buttons    = btn_q;
  assign bus.data_valid = dv_q;
  assign bus.busy       = busy_q;

endmodule

// File: doc/jstk_spi_poller.md
Name: jstk_spi_poller

Overview:
- SPI master and poll scheduler for the PmodJSTK joystick on the MISO/MOSI/SCLK/SS pins of the Space Invaders top level.
- Runs one 5-byte joystick frame every POLL_PERIOD clocks while enabled, and sends the LED command in byte 0.
- Presents the captured X, Y and button data to game logic as one atomic update, marked by a one-cycle valid pulse.

Parameters:
- CLK_DIV, 50: ClkPort cycles per SCLK half-period (100 MHz gives 1 MHz SCLK); minimum 2.
- SS_SETUP, 1500: cycles between SS falling and the first SCLK rising edge (15 us).
- BYTE_GAP, 1000: idle cycles, SCLK low and SS held low, between consecutive bytes (10 us).
- POLL_PERIOD, 1000000: cycles between frame starts, measured SS-fall to SS-fall (10 ms).

Ports:
- ClkPort  in  1  system clock, 100 MHz.
- Reset  in  1  asynchronous, active-high reset.
- poll_en  in  1  enables periodic polling.
- led_cmd  in  2  joystick LED bits; sampled at frame start.
- MISO  in  1  serial data from the joystick.
- SS  out  1  slave select, active low.
- SCLK  out  1  SPI clock, mode 0 (idle low).
- MOSI  out  1  serial data to the joystick.
- x_pos  out  10  last X sample.
- y_pos  out  10  last Y sample.
- buttons  out  3  {btn2, btn1, trigger}, 1 = pressed.
- data_valid  out  1  one-cycle pulse when x_pos/y_pos/buttons update.
- busy  out  1  high from SS fall until SS rise.

Behaviour:
- Reset values, applied immediately on Reset=1 from any state: SS=1, SCLK=0, MOSI=0, x_pos=0, y_pos=0, buttons=0, data_valid=0, busy=0, all counters cleared, FSM in IDLE.
- States: IDLE, SETUP, XFER, GAP, DONE, WAIT.
- IDLE: when poll_en=1, the next edge does the following:
  - SS<=0, busy<=1.
  - Latch tx byte0 = {6'b100000, led_cmd}; bytes 1-4 transmit 8'h00.
  - Clear the poll counter, which then increments every cycle until the next frame start.
  - Go to SETUP.
- SETUP: count SS_SETUP cycles with MOSI = bit 7 of byte0, then go to XFER.
- XFER: 8 bits, MSB first. Each bit is CLK_DIV cycles of SCLK=0 followed by CLK_DIV cycles of SCLK=1.
  - MISO is sampled on the cycle SCLK rises.
  - MOSI changes only when SCLK falls; it already holds the current byte's bit 7 at byte start.
  - After the 8th high phase, SCLK returns to 0.
  - Byte index <4: go to GAP.
  - Byte index 4: go to DONE.
- GAP: BYTE_GAP cycles with SCLK=0 and MOSI = next byte bit 7, then back to XFER with byte index +1.
- DONE (1 cycle): SS<=1, busy<=0, data_valid<=1. Outputs update in the same cycle:
  - x_pos = {rx1[1:0], rx0}
  - y_pos = {rx3[1:0], rx2}
  - buttons = rx4[2:0]
  - Then go to WAIT.
- WAIT: hold until the poll counter reaches POLL_PERIOD-1, then:
  - poll_en=1: start a new frame (same actions as IDLE start).
  - poll_en=0: go to IDLE.
- If the frame length is at least POLL_PERIOD, the next frame starts on the cycle after DONE. SS is high for at least 1 cycle between frames.
- poll_en falling mid-frame does not abort the frame. It completes and publishes, and the block then returns to IDLE at the end of WAIT.
- Outputs hold their last values between frames. A frame interrupted by Reset publishes nothing.
- data_valid is never high for two consecutive cycles.
- led_cmd changes mid-frame do not affect the frame in progress.

Test Plan (parameters CLK_DIV=2, SS_SETUP=4, BYTE_GAP=3, POLL_PERIOD=300):
- Reset asserted mid-XFER:
  - Required: SS=1, SCLK=0, busy=0 in the same cycle, with no data_valid.
  - After release with poll_en=1: a fresh frame starts with byte index 0.
- poll_en=1, led_cmd=2'b10, slave model returns 8'h5A,8'h03,8'hC1,8'h02,8'h05:
  - MOSI stream = 8'h82,00,00,00,00.
  - x_pos=10'h35A, y_pos=10'h2C1, buttons=3'b101, single data_valid pulse.
- SCLK/SS timing on the same frame:
  - 4 cycles from SS fall to the first SCLK rise.
  - Each SCLK period is 4 cycles, 40 SCLK rises in total.
  - 3-cycle gaps between bytes.
  - MOSI stable across every rising edge.
- Continuous poll_en=1:
  - Successive SS falls are exactly 300 cycles apart.
  - One data_valid per frame.
- poll_en dropped during byte 2:
  - The frame completes and publishes.
  - No further SS fall after WAIT; busy=0 and FSM in IDLE.
- led_cmd changed from 2'b01 to 2'b11 during byte 0:
  - The current frame sends 8'h81.
  - The next frame sends 8'h83.
